// File: rtl/mo_linebuf_ctrl.sv
// Ping-pong line buffer controller for the motion-object layer.
// One 256x4 bank is displayed (read with clear-behind-read) while the
// other bank collects pixels for the next scanline from the MO engine.
//
// Write handshake: a write transfers in every cycle where wr_valid and
// wr_ready are both high. wr_ready is high only in RUN, so the engine
// must hold wr_valid/wr_x/wr_color until it sees wr_ready. A transfer
// with the transparent colour completes but leaves the RAM untouched.
module mo_linebuf_ctrl #(
  parameter int         LINE_LEN = 256,
  parameter logic [3:0] TRANSP   = 4'h0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       line_start,
  input  logic       pix_ce,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [7:0] wr_x,
  input  logic [3:0] wr_color,
  output logic [7:0] ram0_a,
  output logic [3:0] ram0_i,
  output logic       ram0_w,
  input  logic [3:0] ram0_d,
  output logic [7:0] ram1_a,
  output logic [3:0] ram1_i,
  output logic       ram1_w,
  input  logic [3:0] ram1_d,
  output logic [3:0] pix_out,
  output logic       pix_valid,
  output logic       disp_bank,
  output logic       overrun,
  output logic [1:0] dbg_state
);

  localparam logic [7:0] X_LAST = 8'(LINE_LEN - 1);

  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_RUN   = 2'd1,
    S_CLEAR = 2'd2,
    S_SWAP  = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] rd_x_q, rd_x_d;
  logic       rd_done_q, rd_done_d;
  logic       disp_bank_q, disp_bank_d;
  logic       overrun_q, overrun_d;
  logic       pv_q, pv_d;
  logic       rd_bank_q;
  logic [3:0] pix_hold_q;
  logic [7:0] a0_q, a1_q;

  // Display-side and write-side RAM requests, before bank steering
  logic       d_act, d_we;
  logic [7:0] d_a;
  logic       w_act, w_we;
  logic [7:0] w_a;
  logic [3:0] w_data;

  // Per-bank requests after steering
  logic       b0_act, b0_we, b1_act, b1_we;
  logic [7:0] b0_a, b1_a;
  logic [3:0] b0_data, b1_data;

  // Next-state logic and RAM requests for each phase of the line
  always_comb begin
    state_d     = state_q;
    rd_x_d      = rd_x_q;
    rd_done_d   = rd_done_q;
    disp_bank_d = disp_bank_q;
    overrun_d   = overrun_q | (line_start && (state_q != S_RUN));
    pv_d        = 1'b0;
    wr_ready    = 1'b0;
    d_act       = 1'b0;
    d_we        = 1'b0;
    d_a         = rd_x_q;
    w_act       = 1'b0;
    w_we        = 1'b0;
    w_a         = wr_x;
    w_data      = TRANSP;
    case (state_q)
      S_INIT: begin
        // Both banks are wiped together, one address per clock
        d_act  = 1'b1;
        d_we   = 1'b1;
        w_act  = 1'b1;
        w_we   = 1'b1;
        w_a    = rd_x_q;
        rd_x_d = rd_x_q + 8'd1;
        if (rd_x_q == 8'd255) begin
          state_d = S_RUN;
          rd_x_d  = 8'd0;
        end
      end
      S_RUN: begin
        wr_ready = 1'b1;
        if (wr_valid) begin
          w_act  = 1'b1;
          w_a    = wr_x;
          w_data = wr_color;
          w_we   = (wr_color != TRANSP);
        end
        // Read the old pixel and clear it in the same RAM cycle
        if (pix_ce && !rd_done_q) begin
          d_act = 1'b1;
          d_we  = 1'b1;
          pv_d  = 1'b1;
          if (rd_x_q == X_LAST) rd_done_d = 1'b1;
          else                  rd_x_d    = rd_x_q + 8'd1;
        end
        // The decision sees this clock's read already counted
        if (line_start) state_d = rd_done_d ? S_SWAP : S_CLEAR;
      end
      S_CLEAR: begin
        // Finish wiping the unread tail so the bank returns empty
        d_act = 1'b1;
        d_we  = 1'b1;
        if (rd_x_q == X_LAST) state_d = S_SWAP;
        else                  rd_x_d  = rd_x_q + 8'd1;
      end
      S_SWAP: begin
        disp_bank_d = ~disp_bank_q;
        rd_x_d      = 8'd0;
        rd_done_d   = 1'b0;
        state_d     = S_RUN;
      end
      default: state_d = S_INIT;
    endcase
  end

  // Steer display/write requests onto the physical banks
  always_comb begin
    if (disp_bank_q) begin
      b0_act = w_act;  b0_we = w_we;  b0_a = w_a;  b0_data = w_data;
      b1_act = d_act;  b1_we = d_we;  b1_a = d_a;  b1_data = TRANSP;
    end else begin
      b0_act = d_act;  b0_we = d_we;  b0_a = d_a;  b0_data = TRANSP;
      b1_act = w_act;  b1_we = w_we;  b1_a = w_a;  b1_data = w_data;
    end
  end

  // Idle banks keep their previous address; strobes are forced off in reset
  assign ram0_a    = b0_act ? b0_a : a0_q;
  assign ram0_i    = b0_data;
  assign ram0_w    = ~(b0_we & ~reset);
  assign ram1_a    = b1_act ? b1_a : a1_q;
  assign ram1_i    = b1_data;
  assign ram1_w    = ~(b1_we & ~reset);

  // Read data arrives one clock after the address; show it that clock
  assign pix_out   = pv_q ? (rd_bank_q ? ram1_d : ram0_d) : pix_hold_q;
  assign pix_valid = pv_q;
  assign disp_bank = disp_bank_q;
  assign overrun   = overrun_q;
  assign dbg_state = state_q;

  // State, counters and output holding registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_INIT;
      rd_x_q      <= 8'd0;
      rd_done_q   <= 1'b0;
      disp_bank_q <= 1'b0;
      overrun_q   <= 1'b0;
      pv_q        <= 1'b0;
      rd_bank_q   <= 1'b0;
      pix_hold_q  <= 4'h0;
      a0_q        <= 8'd0;
      a1_q        <= 8'd0;
    end else begin
      state_q     <= state_d;
      rd_x_q      <= rd_x_d;
      rd_done_q   <= rd_done_d;
      disp_bank_q <= disp_bank_d;
      overrun_q   <= overrun_d;
      pv_q        <= pv_d;
      if (pv_d) rd_bank_q  <= disp_bank_q;
      if (pv_q) pix_hold_q <= pix_out;
      a0_q        <= ram0_a;
      a1_q        <= ram1_a;
    end
  end

endmodule

// File: tb/tb_mo_linebuf_ctrl.sv
// Bench for mo_linebuf_ctrl: two behavioural RAMs, a line-image model of
// both banks, an expected-pixel queue and a per-cycle pixel compare.
// A second instance with LINE_LEN=64 exercises the short-line limit.
module tb_mo_linebuf_ctrl;

  localparam int LL = 256;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset = 1'b1;

  // ---------------- instance A (LINE_LEN=256) ----------------
  logic       line_start, pix_ce, wr_valid;
  logic [7:0] wr_x;
  logic [3:0] wr_color;
  logic       wr_ready;
  logic [7:0] ram0_a, ram1_a;
  logic [3:0] ram0_i, ram1_i, ram0_d, ram1_d;
  logic       ram0_w, ram1_w;
  logic [3:0] pix_out;
  logic       pix_valid, disp_bank, overrun;
  logic [1:0] dbg_state;

  mo_linebuf_ctrl #(.LINE_LEN(256), .TRANSP(4'h0)) dut (
    .clk(clk), .reset(reset), .line_start(line_start), .pix_ce(pix_ce),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_x(wr_x), .wr_color(wr_color),
    .ram0_a(ram0_a), .ram0_i(ram0_i), .ram0_w(ram0_w), .ram0_d(ram0_d),
    .ram1_a(ram1_a), .ram1_i(ram1_i), .ram1_w(ram1_w), .ram1_d(ram1_d),
    .pix_out(pix_out), .pix_valid(pix_valid), .disp_bank(disp_bank),
    .overrun(overrun), .dbg_state(dbg_state)
  );

  // Behavioural 256x4 synchronous RAMs, read-before-write
  logic [3:0] mem0 [256];
  logic [3:0] mem1 [256];
  always @(posedge clk) begin
    ram0_d <= mem0[ram0_a];
    if (!ram0_w) mem0[ram0_a] <= ram0_i;
    ram1_d <= mem1[ram1_a];
    if (!ram1_w) mem1[ram1_a] <= ram1_i;
  end

  // ---------------- instance B (LINE_LEN=64) ----------------
  logic       b_line_start, b_pix_ce, b_wr_valid;
  logic [7:0] b_wr_x;
  logic [3:0] b_wr_color, b_ram0_d, b_ram1_d;
  logic       b_wr_ready;
  logic [7:0] b_ram0_a, b_ram1_a;
  logic [3:0] b_ram0_i, b_ram1_i, b_pix_out;
  logic       b_ram0_w, b_ram1_w, b_pix_valid, b_disp_bank, b_overrun;
  logic [1:0] b_dbg_state;

  mo_linebuf_ctrl #(.LINE_LEN(64), .TRANSP(4'h0)) dut_b (
    .clk(clk), .reset(reset), .line_start(b_line_start), .pix_ce(b_pix_ce),
    .wr_valid(b_wr_valid), .wr_ready(b_wr_ready), .wr_x(b_wr_x), .wr_color(b_wr_color),
    .ram0_a(b_ram0_a), .ram0_i(b_ram0_i), .ram0_w(b_ram0_w), .ram0_d(b_ram0_d),
    .ram1_a(b_ram1_a), .ram1_i(b_ram1_i), .ram1_w(b_ram1_w), .ram1_d(b_ram1_d),
    .pix_out(b_pix_out), .pix_valid(b_pix_valid), .disp_bank(b_disp_bank),
    .overrun(b_overrun), .dbg_state(b_dbg_state)
  );

  // ---------------- model / scoreboard ----------------
  logic [3:0] exp_q[$];
  logic [3:0] rx_log[$];
  logic [3:0] m_line [2][256];
  int         m_disp, m_reads;
  bit         m_run, m_ovr;
  bit         rd_issue, pv_prev;
  logic [3:0] last_out, exp_pix;
  int         n_cmp = 0;
  int         n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Pixel compare: every cycle out of reset, pix_valid must follow an
  // issued read by exactly one clock and pix_out must hold otherwise
  always @(negedge clk) begin
    if (reset) begin
      pv_prev  = 1'b0;
      last_out = 4'h0;
    end else begin
      chk("pix_valid", 32'(pix_valid), 32'(pv_prev));
      if (pv_prev) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL exp_q_empty: got pixel %0h with no read outstanding", pix_out);
        end else begin
          exp_pix = exp_q.pop_front();
          chk("pix_out", 32'(pix_out), 32'(exp_pix));
        end
        rx_log.push_back(pix_out);
        last_out = pix_out;
      end else begin
        chk("pix_hold", 32'(pix_out), 32'(last_out));
      end
      pv_prev = rd_issue;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic model_reset();
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < 256; i++) m_line[b][i] = 4'h0;
    m_disp  = 0;
    m_reads = 0;
    m_run   = 1'b1;
    m_ovr   = 1'b0;
    exp_q.delete();
  endtask

  task automatic chk_reset_vals();
    @(negedge clk);
    chk("rst_wr_ready",  32'(wr_ready),  32'(0));
    chk("rst_pix_valid", 32'(pix_valid), 32'(0));
    chk("rst_pix_out",   32'(pix_out),   32'(0));
    chk("rst_overrun",   32'(overrun),   32'(0));
    chk("rst_disp_bank", 32'(disp_bank), 32'(0));
    chk("rst_strobes",   32'({ram0_w, ram1_w}), 32'(2'b11));
  endtask

  // Expects 256 clocks of both banks written with address 0..255
  task automatic check_init();
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      chk("init_strobes", 32'({ram0_w, ram1_w}), 32'(0));
      chk("init_a0", 32'(ram0_a), 32'(i));
      chk("init_a1", 32'(ram1_a), 32'(i));
      chk("init_data", 32'({ram0_i, ram1_i}), 32'(0));
      chk("init_wr_ready", 32'(wr_ready), 32'(0));
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("run_wr_ready", 32'(wr_ready), 32'(1));
    chk("run_disp_bank", 32'(disp_bank), 32'(0));
    @(posedge clk); #1;
  endtask

  task automatic check_mem(input string name);
    int d0, d1;
    d0 = 0;
    d1 = 0;
    for (int i = 0; i < 256; i++) begin
      if (mem0[i] !== m_line[0][i]) d0++;
      if (mem1[i] !== m_line[1][i]) d1++;
    end
    chk({name, "_bank0_diffs"}, 32'(d0), 32'(0));
    chk({name, "_bank1_diffs"}, 32'(d1), 32'(0));
  endtask

  // One RUN clock with the given inputs; updates the line model
  task automatic cyc(input bit pce, input bit ls, input bit wv,
                     input logic [7:0] x, input logic [3:0] c);
    pix_ce = pce; line_start = ls; wr_valid = wv; wr_x = x; wr_color = c;
    rd_issue = 1'b0;
    if (m_run && pce && m_reads < LL) begin
      exp_q.push_back(m_line[m_disp][m_reads]);
      m_line[m_disp][m_reads] = 4'h0;
      m_reads++;
      rd_issue = 1'b1;
    end
    if (m_run && wv && c != 4'h0) m_line[1 - m_disp][x] = c;
    @(negedge clk);
    if (wv) begin
      chk("wr_ready", 32'(wr_ready), 32'(1));
      chk("wr_strobe", 32'((m_disp == 0) ? ram1_w : ram0_w), 32'(c == 4'h0));
      chk("wr_addr", 32'((m_disp == 0) ? ram1_a : ram0_a), 32'(x));
    end
    @(posedge clk); #1;
    pix_ce = 1'b0; line_start = 1'b0; wr_valid = 1'b0;
    rd_issue = 1'b0;
  endtask

  // line_start, then count clocks without wr_ready until RUN returns.
  // Unread pixels are wiped one per clock, then one swap clock.
  task automatic new_line(input bit pce, input int ovr_at);
    int n, exp_n;
    cyc(pce, 1'b1, 1'b0, 8'h0, 4'h0);
    exp_n = (LL - m_reads) + 1;
    for (int i = m_reads; i < LL; i++) m_line[m_disp][i] = 4'h0;
    m_run = 1'b0;
    n = 0;
    while (n < 600) begin
      line_start = (n == ovr_at);
      if (n == ovr_at) m_ovr = 1'b1;
      @(negedge clk);
      if (wr_ready === 1'b1) break;
      n++;
      @(posedge clk); #1;
    end
    line_start = 1'b0;
    chk("line_gap_clocks", 32'(n), 32'(exp_n));
    m_disp  = 1 - m_disp;
    m_reads = 0;
    m_run   = 1'b1;
    chk("swap_disp_bank", 32'(disp_bank), 32'(m_disp));
    chk("overrun", 32'(overrun), 32'(m_ovr));
    @(posedge clk); #1;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  int wx[6] = '{5, 6, 5, 7, 7, 255};
  int wc[6] = '{7, 0, 9, 3, 0, 15};
  int pv_cnt, st0_cnt, st1_cnt, max_a, nb;

  initial begin
    line_start = 0; pix_ce = 0; wr_valid = 0; wr_x = 0; wr_color = 0;
    b_line_start = 0; b_pix_ce = 0; b_wr_valid = 0; b_wr_x = 0; b_wr_color = 0;
    b_ram0_d = 4'h0; b_ram1_d = 4'h0;
    rd_issue = 1'b0;
    model_reset();

    chk_reset_vals();
    @(posedge clk); #1;
    reset = 1'b0;
    check_init();
    check_mem("after_init");

    // Line 0: bank0 displayed (empty) while bank1 is written
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 1'b1, 8'(wx[i]), 4'(wc[i]));
    for (int i = 6; i < 256; i++) cyc(1'b1, 1'b0, 1'b0, 8'h0, 4'h0);
    new_line(1'b0, -1);
    check_mem("line0");

    // Line 1: bank1 displayed, bank0 collects two pixels
    rx_log.delete();
    for (int i = 0; i < 256; i++) begin
      if (i == 3)      cyc(1'b1, 1'b0, 1'b1, 8'd10, 4'h4);
      else if (i == 4) cyc(1'b1, 1'b0, 1'b1, 8'd100, 4'hA);
      else             cyc(1'b1, 1'b0, 1'b0, 8'h0, 4'h0);
    end
    cyc(1'b0, 1'b0, 1'b0, 8'h0, 4'h0);
    chk("line1_count", 32'(rx_log.size()), 32'(256));
    chk("line1_x5",   32'(rx_log[5]),   32'(9));
    chk("line1_x6",   32'(rx_log[6]),   32'(0));
    chk("line1_x7",   32'(rx_log[7]),   32'(3));
    chk("line1_x255", 32'(rx_log[255]), 32'(15));
    chk("line1_x0",   32'(rx_log[0]),   32'(0));
    check_mem("line1");
    new_line(1'b0, -1);

    // Line 2: short read, line_start together with the 100th pix_ce,
    // and a stray line_start during the clear phase
    rx_log.delete();
    for (int i = 0; i < 99; i++) cyc(1'b1, 1'b0, 1'b0, 8'h0, 4'h0);
    new_line(1'b1, 20);
    chk("line2_count", 32'(rx_log.size()), 32'(100));
    chk("line2_x10",   32'(rx_log[10]),    32'(4));
    check_mem("after_clear");

    // Line 3: writes pending on bank0, then reset mid-line
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 1'b1, 8'(i + 20), 4'(i + 1));
    #2;
    reset = 1'b1;
    rd_issue = 1'b0;
    chk_reset_vals();
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    rx_log.delete();
    check_init();
    check_mem("after_reinit");

    // Instance B: 64-pixel line, extra pix_ce must be ignored
    pv_cnt = 0; st0_cnt = 0; st1_cnt = 0; max_a = 0;
    for (int i = 0; i < 70; i++) begin
      b_pix_ce = 1'b1;
      @(negedge clk);
      if (b_ram0_w === 1'b0) begin
        st0_cnt++;
        if (int'(b_ram0_a) > max_a) max_a = int'(b_ram0_a);
      end
      if (b_ram1_w === 1'b0) st1_cnt++;
      if (b_pix_valid === 1'b1) pv_cnt++;
      @(posedge clk); #1;
    end
    b_pix_ce = 1'b0;
    chk("b_pix_valid_count", 32'(pv_cnt), 32'(64));
    chk("b_clear_writes",    32'(st0_cnt), 32'(64));
    chk("b_last_addr",       32'(max_a),  32'(63));
    chk("b_bank1_writes",    32'(st1_cnt), 32'(0));
    b_line_start = 1'b1;
    @(posedge clk); #1;
    b_line_start = 1'b0;
    nb = 0;
    while (nb < 50) begin
      @(negedge clk);
      if (b_wr_ready === 1'b1) break;
      nb++;
      @(posedge clk); #1;
    end
    chk("b_swap_clocks", 32'(nb), 32'(1));
    chk("b_disp_bank",   32'(b_disp_bank), 32'(1));
    chk("b_overrun",     32'(b_overrun),   32'(0));
    @(posedge clk); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
